// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   fetch_state_t : fetch sequencer FSM encoding (IDLE=0, RUN=1, HALT=2)
//   DEPTH_DEFAULT : default instruction ROM word count
//   NOP_INSTR     : instruction word held in IF/ID while it is empty
//   sat_inc32     : saturating +1 for 32-bit event counters
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    localparam int          DEPTH_DEFAULT = 32;
    localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_seq_ctrl_if_id_reg.sv
// IF/ID pipeline register: captures a fetched instruction and its word
// address on load, drops the valid flag on flush, otherwise holds.
// Flush has priority over load. Reset is asynchronous, so the entry is
// discarded the moment rst_n falls.
// Ports:
//   clk, rst_n       : clock, async active-low reset
//   load, flush      : capture new entry / invalidate entry
//   instr_d, pc_d    : entry to capture
//   instr, pc, valid : registered entry
module if_id_reg
    import cpu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         flush,
    input  logic [N-1:0] instr_d,
    input  logic [N-1:0] pc_d,
    output logic [N-1:0] instr,
    output logic [N-1:0] pc,
    output logic         valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr <= N'(NOP_INSTR);
            pc    <= '0;
            valid <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            instr <= instr_d;
            pc    <= pc_d;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_seq_ctrl.sv
// Instruction fetch sequencer: owns the program counter and the
// IDLE/RUN/HALT control FSM, reads a combinational word-addressed ROM and
// feeds the IF/ID register (sub-module if_id_reg).
// Optional feature: define FETCH_PERF_EN to enable saturating fetch/stall
// event counters; when undefined both counter ports are tied to 0.
// Ports:
//   clk, rst_n                   : clock, async active-low reset
//   start, halt_req              : begin/resume fetching, stop fetching
//   id_ready                     : decode consumes the IF/ID entry
//   redirect_valid, redirect_pc  : branch/jump target (word address)
//   rom_addr, rom_instr          : ROM read port (rom_addr = pc)
//   if_id_instr/pc/valid         : IF/ID register outputs
//   busy, state, addr_err        : status (addr_err sticky until reset)
//   fetch_count, stall_count     : performance counters
module fetch_seq_ctrl
    import cpu_pkg::*;
#(
    parameter int N        = 32,
    parameter int DEPTH    = DEPTH_DEFAULT,
    parameter int RESET_PC = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         halt_req,
    input  logic         id_ready,
    input  logic         redirect_valid,
    input  logic [N-1:0] redirect_pc,
    output logic [N-1:0] rom_addr,
    input  logic [N-1:0] rom_instr,
    output logic [N-1:0] if_id_instr,
    output logic [N-1:0] if_id_pc,
    output logic         if_id_valid,
    output logic         busy,
    output logic [1:0]   state,
    output logic         addr_err,
    output logic [31:0]  fetch_count,
    output logic [31:0]  stall_count
);

    // One extra bit so DEPTH == 2**N still compares correctly.
    localparam logic [N:0]   DEPTH_EXT = (N+1)'(DEPTH);
    localparam logic [N-1:0] LAST_PC   = N'(DEPTH - 1);
    localparam logic [N-1:0] START_PC  = N'(RESET_PC);

    fetch_state_t state_q, state_d;
    logic [N-1:0] pc_q, pc_d;
    logic         addr_err_q, addr_err_d;
    logic         load, flush;
    logic         redirect_bad;
    logic [N-1:0] pc_next_seq;

    assign redirect_bad = redirect_valid && ({1'b0, redirect_pc} >= DEPTH_EXT);
    assign pc_next_seq  = (pc_q == LAST_PC) ? '0 : pc_q + N'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= START_PC;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_err_q <= addr_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_err_d = addr_err_q;
        load       = 1'b0;
        flush      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = START_PC;
                end
            end
            ST_RUN: begin
                if (redirect_valid) begin
                    // Redirect overrides both load and stall.
                    flush = 1'b1;
                    if (redirect_bad) begin
                        addr_err_d = 1'b1;
                        state_d    = ST_HALT;
                    end else begin
                        pc_d = redirect_pc;
                    end
                end else begin
                    load = !if_id_valid || id_ready;
                    if (load) pc_d = pc_next_seq;
                end
                if (halt_req) state_d = ST_HALT;
            end
            ST_HALT: begin
                if (redirect_valid) begin
                    flush = 1'b1;
                    if (redirect_bad) addr_err_d = 1'b1;
                    else              pc_d       = redirect_pc;
                end else if (if_id_valid && id_ready) begin
                    // Decode drains the held entry; nothing replaces it.
                    flush = 1'b1;
                end
                if (start && !halt_req && !addr_err_q && !redirect_bad)
                    state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    if_id_reg #(.N(N)) u_if_id (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .flush   (flush),
        .instr_d (rom_instr),
        .pc_d    (pc_q),
        .instr   (if_id_instr),
        .pc      (if_id_pc),
        .valid   (if_id_valid)
    );

    assign rom_addr = pc_q;
    assign busy     = (state_q == ST_RUN);
    assign state    = state_q;
    assign addr_err = addr_err_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;
    logic        stall_ev;

    // A redirect cycle is neither a fetch nor a stall.
    assign stall_ev = (state_q == ST_RUN) && !load && !redirect_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (load)     fetch_cnt_q <= sat_inc32(fetch_cnt_q);
            if (stall_ev) stall_cnt_q <= sat_inc32(stall_cnt_q);
        end
    end

    assign fetch_count = fetch_cnt_q;
    assign stall_count = stall_cnt_q;
`else
    assign fetch_count = 32'd0;
    assign stall_count = 32'd0;
`endif

endmodule

// File: doc/fetch_seq_ctrl.md
FETCH_SEQ_CTRL -- requirements
Module: fetch_seq_ctrl

Interface
REQ-001 SHALL take parameter N, default 32: instruction and address width.
REQ-002 SHALL take parameter DEPTH, default 32: instruction ROM word count; legal word addresses are 0..DEPTH-1.
REQ-003 SHALL take parameter RESET_PC, default 0: start word address.
REQ-004 SHALL have ports `clk` (in, 1, sole clock, rising edge) and `rst_n` (in, 1); reset is asynchronous and active-low.
REQ-005 SHALL have `start` (in, 1): pulse that begins or resumes fetching.
REQ-006 SHALL have `halt_req` (in, 1): stop issuing fetches.
REQ-007 SHALL have `id_ready` (in, 1): decode consumes the IF/ID entry this cycle.
REQ-008 SHALL have `redirect_valid` (in, 1) and `redirect_pc` (in, N): branch/jump target as a word address.
REQ-009 SHALL have `rom_addr` (out, N) and `rom_instr` (in, N): word-indexed, combinational-read ROM port.
REQ-010 SHALL have `if_id_instr` (out, N), `if_id_pc` (out, N) and `if_id_valid` (out, 1): IF/ID pipeline register.
REQ-011 SHALL have `busy` (out, 1), `state` (out, 2) and `addr_err` (out, 1, sticky).
REQ-012 SHALL have `fetch_count` (out, 32) and `stall_count` (out, 32).

Function
REQ-013 SHALL implement FSM states IDLE=0, RUN=1, HALT=2; `busy`=1 only in RUN.
REQ-014 SHALL drive `rom_addr`=pc combinationally in every state.
REQ-015 IDLE: `start` -> RUN with pc=RESET_PC; `if_id_valid`=0; `halt_req` ignored.
REQ-016 Latency: `start` at cycle t -> RUN at t+1 -> first `if_id_valid`=1 at t+2.
REQ-017 RUN: load = !`if_id_valid` || `id_ready`.
- On load, capture `rom_instr`/pc into IF/ID and set valid=1.
- pc <= (pc==DEPTH-1) ? 0 : pc+1, i.e. wrap-around.
REQ-018 RUN, !load (stall): pc, `if_id_instr`, `if_id_pc` and `if_id_valid` SHALL hold unchanged.
REQ-019 In RUN or HALT, `redirect_valid` SHALL beat load and stall.
- Sets pc <= `redirect_pc` and flushes `if_id_valid` <= 0 next cycle, regardless of `id_ready`.
REQ-020 `redirect_pc` >= DEPTH SHALL set `addr_err`=1, flush IF/ID, leave pc unchanged and go to HALT.
REQ-021 RUN, `halt_req` -> HALT; a redirect in the same cycle is still applied to pc.
REQ-022 HALT: no loads; a held valid entry clears when `id_ready`=1.
- `start` -> RUN, resuming from the current pc, unless `addr_err`=1.
- `halt_req` and `start` together: stay in HALT.
REQ-023 `start` in RUN SHALL be ignored.

Reset
REQ-024 While `rst_n`=0, the block SHALL hold: state=IDLE, pc=RESET_PC, `if_id_instr`=0, `if_id_pc`=0, `if_id_valid`=0, `addr_err`=0, both counters 0.
REQ-025 Reset asserted mid-RUN SHALL discard the IF/ID contents immediately, without waiting for a clock edge.
REQ-026 `addr_err` SHALL clear only on reset.

Configuration
REQ-027 Macro FETCH_PERF_EN defined:
- `fetch_count` increments on each load.
- `stall_count` increments on each RUN cycle with !load and !redirect.
- Both saturate at 0xFFFFFFFF.
REQ-028 Macro FETCH_PERF_EN undefined: both counter ports SHALL be present and constant 0.

Structure
REQ-029 Shared package cpu_pkg SHALL hold the FSM state encoding, the DEPTH default and the NOP encoding 32'h00000000.
REQ-030 The IF/ID register SHALL be the sub-module `if_id_reg` (load, flush, hold); pc and FSM stay in the top level.

Verification
REQ-031 Reset, `start`, `id_ready`=1 held -> `if_id_pc` 0,1,2..., with `if_id_instr`=0x00221820 when `if_id_pc`=0; `fetch_count`=3 after three loads.
REQ-032 `id_ready`=0 for 3 cycles with the entry at `if_id_pc`=1 -> pc=2 and entry held; `stall_count`=3.
REQ-033 `redirect_valid`=1, `redirect_pc`=16 while stalled -> next cycle `if_id_valid`=0; following cycle `if_id_pc`=16, `if_id_instr`=0x00221820.
REQ-034 pc=31 (DEPTH=32), load -> pc=0; `if_id_pc`=31.
REQ-035 `redirect_pc`=40 -> `addr_err`=1, state=HALT; a later `start` is ignored; `rst_n` pulse clears `addr_err`.
REQ-036 `halt_req` with a valid entry, then `id_ready`=1 -> `if_id_valid`=0 and pc frozen; `start` -> resumes at the frozen pc.
